exu_trap: RTL and testbench

- Machine-mode trap commit stage, directly downstream of the execute-stage exception/interrupt controller.
- Consumes its trap-enable and mcause outputs together with the committing instruction's PC.
- Owns the mstatus, mtvec, mepc and mcause CSRs and sequences trap entry and mret.
- Issues a one-cycle pipeline flush with a redirect PC toward fetch.

---
 rtl/exu_trap_if.sv | 23 ++
 rtl/exu_trap.sv | 101 ++++++++++
 tb/tb_exu_trap.sv | 127 ++++++++++++
 3 files changed

// File: rtl/exu_trap_if.sv
// exu_trap_if: commit-side handshake, CSR access and flush bundle for exu_trap
interface exu_trap_if;
   logic        i_vld;
   logic        o_rdy;
   logic [31:0] i_pc;
   logic        i_int_ena;
   logic [31:0] i_mcause;
   logic        i_mret;
   logic        i_csr_we;
   logic [11:0] i_csr_addr;
   logic [31:0] i_csr_wdata;
   logic [31:0] o_csr_rdata;
   logic        o_flush;
   logic [31:0] o_flush_pc;
   modport master (
      output i_vld, i_pc, i_int_ena, i_mcause, i_mret, i_csr_we, i_csr_addr, i_csr_wdata,
      input  o_rdy, o_csr_rdata, o_flush, o_flush_pc
   );
   modport slave (
      input  i_vld, i_pc, i_int_ena, i_mcause, i_mret, i_csr_we, i_csr_addr, i_csr_wdata,
      output o_rdy, o_csr_rdata, o_flush, o_flush_pc
   );
endinterface

// File: rtl/exu_trap.sv
// exu_trap: machine-mode trap commit stage owning mstatus/mtvec/mepc/mcause
module exu_trap #(
   parameter logic [31:0] MTVEC_RST = 32'h0000_0080
) (
   input logic        clk,
   input logic        rst,
   exu_trap_if.slave  bus
);
   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   typedef enum logic [1:0] {IDLE, TRAP, MRET, FLUSH} state_t;
   state_t      state_q, state_d;
   logic        mie_q, mie_d, mpie_q, mpie_d, rdy_q, rdy_d, flush_q, flush_d;
   logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic [31:0] cap_pc_q, cap_pc_d, cap_cause_q, cap_cause_d, flush_pc_q, flush_pc_d;
   logic        xfer;
   assign xfer = bus.i_vld & rdy_q;
   always_comb begin
      state_d     = state_q;
      mie_d       = mie_q;
      mpie_d      = mpie_q;
      mtvec_d     = mtvec_q;
      mepc_d      = mepc_q;
      mcause_d    = mcause_q;
      cap_pc_d    = cap_pc_q;
      cap_cause_d = cap_cause_q;
      flush_pc_d  = flush_pc_q;
      unique case (state_q)
         IDLE: if (xfer) begin
            if (bus.i_int_ena) begin
               cap_pc_d    = bus.i_pc;
               cap_cause_d = bus.i_mcause;
               state_d     = TRAP;
            end else if (bus.i_mret) begin
               state_d = MRET;
            end else if (bus.i_csr_we) begin
               mie_d    = bus.i_csr_addr == A_MSTATUS ? bus.i_csr_wdata[3] : mie_q;
               mpie_d   = bus.i_csr_addr == A_MSTATUS ? bus.i_csr_wdata[7] : mpie_q;
               mtvec_d  = bus.i_csr_addr == A_MTVEC ? {bus.i_csr_wdata[31:2], 2'b00} : mtvec_q;
               mepc_d   = bus.i_csr_addr == A_MEPC ? {bus.i_csr_wdata[31:2], 2'b00} : mepc_q;
               mcause_d = bus.i_csr_addr == A_MCAUSE ? bus.i_csr_wdata : mcause_q;
            end
         end
         TRAP: begin
            mepc_d     = {cap_pc_q[31:2], 2'b00};
            mcause_d   = cap_cause_q;
            mpie_d     = mie_q;
            mie_d      = 1'b0;
            flush_pc_d = mtvec_q;
            state_d    = FLUSH;
         end
         MRET: begin
            mie_d      = mpie_q;
            mpie_d     = 1'b1;
            flush_pc_d = mepc_q;
            state_d    = FLUSH;
         end
         FLUSH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      rdy_d   = state_d == IDLE;
      flush_d = state_d == FLUSH;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mie_q       <= 1'b0;
         mpie_q      <= 1'b0;
         mtvec_q     <= MTVEC_RST;
         mepc_q      <= '0;
         mcause_q    <= '0;
         cap_pc_q    <= '0;
         cap_cause_q <= '0;
         rdy_q       <= 1'b1;
         flush_q     <= 1'b0;
         flush_pc_q  <= '0;
      end else begin
         state_q     <= state_d;
         mie_q       <= mie_d;
         mpie_q      <= mpie_d;
         mtvec_q     <= mtvec_d;
         mepc_q      <= mepc_d;
         mcause_q    <= mcause_d;
         cap_pc_q    <= cap_pc_d;
         cap_cause_q <= cap_cause_d;
         rdy_q       <= rdy_d;
         flush_q     <= flush_d;
         flush_pc_q  <= flush_pc_d;
      end
   end
   assign bus.o_rdy      = rdy_q;
   assign bus.o_flush    = flush_q;
   assign bus.o_flush_pc = flush_pc_q;
   assign bus.o_csr_rdata =
      bus.i_csr_addr == A_MSTATUS ? {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0} :
      bus.i_csr_addr == A_MTVEC   ? mtvec_q :
      bus.i_csr_addr == A_MEPC    ? mepc_q :
      bus.i_csr_addr == A_MCAUSE  ? mcause_q : 32'h0;
endmodule

// File: tb/tb_exu_trap.sv
// tb_exu_trap: scoreboard bench for exu_trap trap entry, mret, CSR map and reset
module tb_exu_trap;
   logic clk = 1'b0;
   logic rst;
   int   errs = 0;
   int   checks = 0;
   logic flush_prev = 1'b0;
   logic [31:0] sb[$];
   exu_trap_if bus ();
   exu_trap #(.MTVEC_RST(32'h0000_0080)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   // every flush must match the oldest pending redirect and never repeat back-to-back
   always @(negedge clk) begin
      if (bus.o_flush) begin
         if (sb.size() == 0) chk("flush_unexpected", 32'd1, 32'd0);
         else chk("flush_pc", bus.o_flush_pc, sb.pop_front());
         chk("flush_consec", {31'b0, flush_prev}, 32'd0);
      end
      flush_prev = bus.o_flush;
   end
   task automatic idle_in;
      bus.i_vld = 0; bus.i_int_ena = 0; bus.i_mret = 0; bus.i_csr_we = 0;
   endtask
   task automatic step;
      @(posedge clk); #1;
   endtask
   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      bus.i_csr_addr = a;
      #1;
      chk(tag, bus.o_csr_rdata, exp);
   endtask
   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus.i_vld = 1; bus.i_csr_we = 1; bus.i_csr_addr = a; bus.i_csr_wdata = d;
      step();
      idle_in();
   endtask
   task automatic commit(input logic ie, input logic mr, input logic we, input logic [11:0] a,
                         input logic [31:0] d, input logic [31:0] pc, input logic [31:0] cause,
                         input logic [31:0] exp_pc);
      bus.i_vld = 1; bus.i_int_ena = ie; bus.i_mret = mr; bus.i_csr_we = we;
      bus.i_csr_addr = a; bus.i_csr_wdata = d; bus.i_pc = pc; bus.i_mcause = cause;
      sb.push_back(exp_pc);
      step();
      idle_in();
      chk("rdy_n1", {31'b0, bus.o_rdy}, 32'd0);
      chk("flush_n1", {31'b0, bus.o_flush}, 32'd0);
      step();
      chk("rdy_n2", {31'b0, bus.o_rdy}, 32'd0);
      chk("flush_n2", {31'b0, bus.o_flush}, 32'd1);
      step();
      chk("rdy_n3", {31'b0, bus.o_rdy}, 32'd1);
      chk("flush_n3", {31'b0, bus.o_flush}, 32'd0);
   endtask
   initial begin
      rst = 1;
      idle_in();
      bus.i_pc = 0; bus.i_mcause = 0; bus.i_csr_addr = 0; bus.i_csr_wdata = 0;
      step(); step();
      rst = 0;
      chk("rst_rdy", {31'b0, bus.o_rdy}, 32'd1);
      chk("rst_flush", {31'b0, bus.o_flush}, 32'd0);
      chk("rst_flush_pc", bus.o_flush_pc, 32'h0);
      rd("rst_mtvec", 12'h305, 32'h80);
      rd("rst_mstatus", 12'h300, 32'h1800);
      rd("rst_mepc", 12'h341, 32'h0);
      wr(12'h300, 32'h8);
      rd("mstatus_w", 12'h300, 32'h1808);
      commit(1, 0, 0, 12'h341, 0, 32'h1004, 32'hB, 32'h80);
      rd("t2_mepc", 12'h341, 32'h1004);
      rd("t2_mcause", 12'h342, 32'hB);
      rd("t2_mstatus", 12'h300, 32'h1880);
      commit(0, 1, 0, 12'h300, 0, 32'h0, 32'h0, 32'h1004);
      rd("t3_mstatus", 12'h300, 32'h1888);
      commit(1, 0, 1, 12'h305, 32'h200, 32'h2002, 32'h8000_0000, 32'h80);
      rd("t4_mtvec", 12'h305, 32'h80);
      rd("t4_mcause", 12'h342, 32'h8000_0000);
      rd("t4_mepc", 12'h341, 32'h2000);
      wr(12'h305, 32'h203);
      rd("mtvec_mask", 12'h305, 32'h200);
      wr(12'h341, 32'h1007);
      rd("mepc_mask", 12'h341, 32'h1004);
      wr(12'h7C0, 32'hFFFF_FFFF);
      rd("unmapped", 12'h7C0, 32'h0);
      wr(12'h342, 32'h1234_5678);
      rd("mcause_w", 12'h342, 32'h1234_5678);
      // request held through TRAP/FLUSH must not start a second trap
      bus.i_vld = 1; bus.i_int_ena = 1; bus.i_pc = 32'h3000; bus.i_mcause = 32'h5;
      bus.i_csr_addr = 12'h341;
      sb.push_back(32'h200);
      step();
      chk("trap_pre_mepc", bus.o_csr_rdata, 32'h1004);
      step();
      chk("hold_flush", {31'b0, bus.o_flush}, 32'd1);
      step();
      idle_in();
      chk("hold_n3_flush", {31'b0, bus.o_flush}, 32'd0);
      step();
      chk("hold_n4_flush", {31'b0, bus.o_flush}, 32'd0);
      chk("hold_n4_rdy", {31'b0, bus.o_rdy}, 32'd1);
      rd("hold_mepc", 12'h341, 32'h3000);
      bus.i_vld = 1; bus.i_int_ena = 1; bus.i_pc = 32'h4000; bus.i_mcause = 32'h7;
      step();
      idle_in();
      chk("t6_trap_rdy", {31'b0, bus.o_rdy}, 32'd0);
      rst = 1;
      step();
      rst = 0;
      chk("t6_rdy", {31'b0, bus.o_rdy}, 32'd1);
      chk("t6_flush", {31'b0, bus.o_flush}, 32'd0);
      rd("t6_mepc", 12'h341, 32'h0);
      rd("t6_mtvec", 12'h305, 32'h80);
      rd("t6_mstatus", 12'h300, 32'h1800);
      step();
      chk("t6_flush_after", {31'b0, bus.o_flush}, 32'd0);
      step();
      chk("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
